// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch front end: owns the fetch PC, issues one outstanding
// request at a time to a variable-latency instruction memory, and buffers
// returned words in a small FIFO presented to IF/ID as {inst, pc+4}.
module fetch_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       redirect_i,
  input  logic [31:0]                redirect_pc_i,
  input  logic                       stall_i,
  output logic                       imem_req_o,
  output logic [31:0]                imem_addr_o,
  input  logic                       imem_ack_i,
  input  logic [31:0]                imem_rdata_i,
  output logic [31:0]                inst_o,
  output logic [31:0]                pc_adder_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StReq, StDrain} state_e;

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;

  logic [31:0]       inst_mem_q [DEPTH];
  logic [31:0]       pca_mem_q  [DEPTH];

  logic              push, pop, space;
  logic [CntW-1:0]   count_next;
  logic [31:0]       addr_inc;

  // Queue occupancy bookkeeping and head presentation.
  always_comb begin
    valid_o    = (count_q != '0) && !redirect_i;
    pop        = valid_o && !stall_i;
    push       = (state_q == StReq) && imem_ack_i && !redirect_i;
    count_next = count_q + CntW'(push) - CntW'(pop);
    space      = count_next < CntW'(DEPTH);
    addr_inc   = addr_q + 32'd4;
    inst_o     = valid_o ? inst_mem_q[rd_ptr_q] : 32'h0;
    pc_adder_o = valid_o ? pca_mem_q[rd_ptr_q] : 32'h0;
  end

  assign imem_req_o  = req_q;
  assign imem_addr_o = addr_q;
  assign count_o     = count_q;

  // Next-state logic for the request FSM, fetch PC and queue pointers.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q + PtrW'(push);
    rd_ptr_d   = rd_ptr_q + PtrW'(pop);
    count_d    = count_next;

    if (redirect_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = redirect_pc_i;
    end

    unique case (state_q)
      StIdle: begin
        // Only issue when a slot is reserved for the returning word.
        if (!redirect_i && space) begin
          state_d = StReq;
          req_d   = 1'b1;
          addr_d  = fetch_pc_q;
        end
      end
      StReq: begin
        if (redirect_i) begin
          if (imem_ack_i) begin
            state_d = StIdle;
            req_d   = 1'b0;
          end else begin
            // The memory still owes a response; keep asking until it arrives.
            state_d = StDrain;
          end
        end else if (imem_ack_i) begin
          fetch_pc_d = addr_inc;
          if (space) begin
            addr_d = addr_inc;
          end else begin
            state_d = StIdle;
            req_d   = 1'b0;
          end
        end
      end
      StDrain: begin
        if (imem_ack_i) begin
          state_d = StIdle;
          req_d   = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        req_d   = 1'b0;
      end
    endcase
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      req_q      <= 1'b0;
      addr_q     <= 32'h0;
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Queue storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (push) begin
      inst_mem_q[wr_ptr_q] <= imem_rdata_i;
      pca_mem_q[wr_ptr_q]  <= addr_inc;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Self-checking bench for fetch_prefetch_queue: a memory responder with
// configurable latency, a scoreboard of expected {inst, pc+4} entries, a
// table of early-fill cycles, and directed corner-case sequences.
module tb_fetch_prefetch_queue;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        stall_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic [31:0] inst_o;
  logic [31:0] pc_adder_o;
  logic        valid_o;
  logic [2:0]  count_o;

  fetch_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .stall_i       (stall_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_rdata_i  (imem_rdata_i),
    .inst_o        (inst_o),
    .pc_adder_o    (pc_adder_o),
    .valid_o       (valid_o),
    .count_o       (count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pca;
  } ent_t;

  typedef struct {
    logic        stall;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pca;
    logic [2:0]  cnt;
  } vec_t;

  ent_t        sb[$];
  vec_t        tbl[4];
  int          total = 0;
  int          bad = 0;
  int          lat = 1;
  int          wcnt = 0;
  logic        ack_en = 1'b1;
  logic        force_dead = 1'b0;
  logic        draining = 1'b0;
  logic [31:0] exp_addr = 32'h0;
  logic        prev_pending = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hA5C3_0F1E;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    sb.delete();
    exp_addr     = 32'h0;
    draining     = 1'b0;
    wcnt         = 0;
    prev_pending = 1'b0;
    ack_en       = 1'b1;
    force_dead   = 1'b0;
  endtask

  task automatic do_reset(input int latency);
    rst_i = 1'b1;
    redirect_i = 1'b0; redirect_pc_i = '0; stall_i = 1'b0;
    imem_ack_i = 1'b0; imem_rdata_i = '0;
    lat = latency;
    clear_model();
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_i = 1'b0;
    #1;
    chk("rst_req", {31'h0, imem_req_o}, 32'h0);
    chk("rst_addr", imem_addr_o, 32'h0);
    chk("rst_valid", {31'h0, valid_o}, 32'h0);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_pca", pc_adder_o, 32'h0);
    chk("rst_count", {29'h0, count_o}, 32'h0);
  endtask

  // One clock: drive inputs after the edge, then check against the scoreboard.
  task automatic cycle(input logic stall, input logic redir, input logic [31:0] rpc);
    logic ack;
    @(posedge clk_i); #1;
    if (prev_pending) begin
      chk("req_held", {31'h0, imem_req_o}, 32'h1);
      chk("addr_held", imem_addr_o, prev_addr);
    end
    stall_i = stall; redirect_i = redir; redirect_pc_i = rpc;
    ack = ack_en && imem_req_o && (wcnt >= lat - 1);
    imem_ack_i = ack;
    imem_rdata_i = ack ? (force_dead ? 32'hDEAD_BEEF : word(imem_addr_o)) : 32'h0;
    if (imem_req_o) wcnt = ack ? 0 : wcnt + 1;
    prev_pending = imem_req_o && !ack;
    prev_addr = imem_addr_o;
    #1;
    chk("count", {29'h0, count_o}, sb.size());
    if (sb.size() != 0 && !redir) begin
      chk("valid", {31'h0, valid_o}, 32'h1);
      chk("inst", inst_o, sb[0].inst);
      chk("pca", pc_adder_o, sb[0].pca);
      if (!stall) void'(sb.pop_front());
    end else begin
      chk("valid_off", {31'h0, valid_o}, 32'h0);
      chk("inst_off", inst_o, 32'h0);
    end
    if (ack) begin
      if (redir || draining) begin
        draining = 1'b0;
      end else begin
        chk("ack_addr", imem_addr_o, exp_addr);
        sb.push_back('{inst: word(exp_addr), pca: exp_addr + 32'd4});
        exp_addr = exp_addr + 32'd4;
      end
    end
    if (redir) begin
      sb.delete();
      exp_addr = rpc;
      if (imem_req_o && !ack) draining = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{stall: 1'b0, req: 1'b1, addr: 32'h0, valid: 1'b0, pca: 32'h0, cnt: 3'd0};
    tbl[1] = '{stall: 1'b0, req: 1'b1, addr: 32'h4, valid: 1'b1, pca: 32'h4, cnt: 3'd1};
    tbl[2] = '{stall: 1'b0, req: 1'b1, addr: 32'h8, valid: 1'b1, pca: 32'h8, cnt: 3'd1};
    tbl[3] = '{stall: 1'b0, req: 1'b1, addr: 32'hC, valid: 1'b1, pca: 32'hC, cnt: 3'd1};

    // Back-to-back fill with zero-wait memory.
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      cycle(tbl[i].stall, 1'b0, 32'h0);
      chk("t1_req", {31'h0, imem_req_o}, {31'h0, tbl[i].req});
      chk("t1_addr", imem_addr_o, tbl[i].addr);
      chk("t1_valid", {31'h0, valid_o}, {31'h0, tbl[i].valid});
      chk("t1_pca", pc_adder_o, tbl[i].pca);
      chk("t1_count", {29'h0, count_o}, {29'h0, tbl[i].cnt});
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'h0);

    // Stall until full, then release.
    do_reset(1);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 32'h0);
    chk("t2_full", {29'h0, count_o}, 32'd4);
    chk("t2_req_off", {31'h0, imem_req_o}, 32'h0);
    chk("t2_head", inst_o, word(32'h0));
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    chk("t2_resume_req", {31'h0, imem_req_o}, 32'h1);
    chk("t2_resume_addr", imem_addr_o, 32'h10);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'h0);

    // Three-cycle memory latency.
    do_reset(3);
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 32'h0);
    chk("t3_addr", imem_addr_o, 32'h8);
    chk("t3_count", {29'h0, count_o}, 32'd2);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'h0);

    // Redirect with three entries held and the request unanswered.
    do_reset(1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0);
    ack_en = 1'b0;
    cycle(1'b0, 1'b1, 32'h100);
    chk("t4_valid_redir", {31'h0, valid_o}, 32'h0);
    ack_en = 1'b1;
    cycle(1'b0, 1'b0, 32'h0);
    chk("t4_count", {29'h0, count_o}, 32'd0);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    chk("t4_req", {31'h0, imem_req_o}, 32'h1);
    chk("t4_addr", imem_addr_o, 32'h100);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0);

    // Redirect while the request to 0x40 is pending; its late word is dropped.
    do_reset(1);
    ack_en = 1'b0;
    cycle(1'b0, 1'b1, 32'h40);
    ack_en = 1'b1;
    cycle(1'b0, 1'b0, 32'h0);
    ack_en = 1'b0;
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 32'h200);
    chk("t5_pending_addr", imem_addr_o, 32'h40);
    cycle(1'b0, 1'b0, 32'h0);
    ack_en = 1'b1; force_dead = 1'b1;
    cycle(1'b0, 1'b0, 32'h0);
    force_dead = 1'b0;
    cycle(1'b0, 1'b0, 32'h0);
    chk("t5_count", {29'h0, count_o}, 32'd0);
    cycle(1'b0, 1'b0, 32'h0);
    chk("t5_req", {31'h0, imem_req_o}, 32'h1);
    chk("t5_addr", imem_addr_o, 32'h200);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0);

    // Asynchronous reset in the middle of a pending request.
    do_reset(3);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    rst_i = 1'b1;
    #1;
    chk("t6_req_async", {31'h0, imem_req_o}, 32'h0);
    chk("t6_count_async", {29'h0, count_o}, 32'd0);
    stall_i = 1'b0; redirect_i = 1'b0;
    imem_ack_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    lat = 1;
    clear_model();
    #1;
    chk("t6_idle_req", {31'h0, imem_req_o}, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    chk("t6_first_addr", imem_addr_o, 32'h0);
    chk("t6_first_req", {31'h0, imem_req_o}, 32'h1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
